// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - 32-bit RISC-V execute-stage ALU with registered result/zero copy
// Optional shifter (SLL/SRL/SRA) enabled by defining ALU_SHIFT_EN.

module riscv_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  alu_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic [31:0] result_q,
    output logic        zero_q
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_add_ovf;
    logic        w_sub_ovf;
    logic        w_slt;
    logic        w_sltu;
    logic [31:0] w_result;
    logic        w_overflow;

    logic [31:0] r_result_q;
    logic        r_zero_q;

    assign w_sum  = in_a + in_b;
    assign w_diff = in_a - in_b;

    // Signed overflow from sign bits: ADD when like signs flip, SUB when unlike signs flip a's sign.
    assign w_add_ovf = (in_a[31] == in_b[31]) && (w_sum[31]  != in_a[31]);
    assign w_sub_ovf = (in_a[31] != in_b[31]) && (w_diff[31] != in_a[31]);

    assign w_slt  = $signed(in_a) < $signed(in_b);
    assign w_sltu = in_a < in_b;

`ifdef ALU_SHIFT_EN
    logic [4:0]  w_shamt;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;

    assign w_shamt = in_b[4:0];
    assign w_sll   = in_a << w_shamt;
    assign w_srl   = in_a >> w_shamt;
    assign w_sra   = $unsigned($signed(in_a) >>> w_shamt);
`endif

    always_comb begin
        w_result   = 32'h0;
        w_overflow = 1'b0;
        case (alu_op)
            OP_AND:  w_result = in_a & in_b;
            OP_OR:   w_result = in_a | in_b;
            OP_ADD: begin
                w_result   = w_sum;
                w_overflow = w_add_ovf;
            end
            OP_XOR:  w_result = in_a ^ in_b;
            OP_SUB: begin
                w_result   = w_diff;
                w_overflow = w_sub_ovf;
            end
            OP_SLT:  w_result = {31'h0, w_slt};
            OP_SLTU: w_result = {31'h0, w_sltu};
`ifdef ALU_SHIFT_EN
            OP_SLL:  w_result = w_sll;
            OP_SRL:  w_result = w_srl;
            OP_SRA:  w_result = w_sra;
`endif
            default: begin
                w_result   = 32'h0;
                w_overflow = 1'b0;
            end
        endcase
    end

    assign result   = w_result;
    assign zero     = (w_result == 32'h0);
    assign overflow = w_overflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result_q <= 32'h0;
            r_zero_q   <= 1'b1;
        end else begin
            r_result_q <= w_result;
            r_zero_q   <= (w_result == 32'h0);
        end
    end

    assign result_q = r_result_q;
    assign zero_q   = r_zero_q;

endmodule

// File: tb/tb_riscv_alu.sv
// tb/tb_riscv_alu.sv - directed and randomized checks of riscv_alu against a behavioural model
module tb_riscv_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic [31:0] result_q;
    logic        zero_q;

    int n_cmp;
    int n_bad;

    riscv_alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_op   (alu_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .result_q (result_q),
        .zero_q   (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: wide signed arithmetic decides overflow by range, not by sign bits.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ov);
        longint sa;
        longint sb;
        longint wide;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        r  = 32'h0;
        ov = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                wide = sa + sb;
                r    = 32'(wide);
                ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd3: r = a ^ b;
            4'd6: begin
                wide = sa - sb;
                r    = 32'(wide);
                ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
            4'd4: r = 32'(longint'(a) * (64'sd1 << sh));
            4'd5: r = 32'(longint'(a) / (64'sd1 << sh));
            4'd8: r = 32'(sa >>> sh);
`endif
            default: r = 32'h0;
        endcase
    endtask

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rst, input logic [31:0] exp_r, input logic exp_ov);
        @(negedge clk);
        alu_op = op;
        in_a   = a;
        in_b   = b;
        rst_n  = rst;
        #1;
        check($sformatf("result op%0d", op), result, exp_r);
        check($sformatf("zero op%0d", op), 32'(zero), 32'(exp_r == 32'h0));
        check($sformatf("overflow op%0d", op), 32'(overflow), 32'(exp_ov));
        @(posedge clk);
        #1;
        if (!rst) begin
            check("result_q reset", result_q, 32'h0);
            check("zero_q reset", 32'(zero_q), 32'd1);
        end else begin
            check($sformatf("result_q op%0d", op), result_q, exp_r);
            check($sformatf("zero_q op%0d", op), 32'(zero_q), 32'(exp_r == 32'h0));
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h8000_0000;
        corners[1] = 32'h7fff_ffff;
        corners[2] = 32'hffff_ffff;
        corners[3] = 32'h0000_0001;
        corners[4] = 32'h0000_0000;
        case ($urandom_range(0, 3))
            0:       return corners[$urandom_range(0, 4)];
            1:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    logic [31:0] sra_exp;
    logic [31:0] sll_exp;
    logic [31:0] m_r;
    logic        m_ov;

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        alu_op = 4'd0;
        in_a   = 32'h0;
        in_b   = 32'h0;

        // Reset state of the registered path, with nonzero combinational result present.
        apply(4'd2, 32'd5, 32'd6, 1'b0, 32'd11, 1'b0);
        apply(4'd1, 32'h0f0f_0f0f, 32'h1, 1'b0, 32'h0f0f_0f0f, 1'b0);

`ifdef ALU_SHIFT_EN
        sra_exp = 32'hf800_0000;
        sll_exp = 32'h0000_0020;
`else
        sra_exp = 32'h0;
        sll_exp = 32'h0;
`endif

        apply(4'd2, 32'd5,          32'd6,          1'b1, 32'd11,         1'b0);
        apply(4'd0, 32'hffff_ffff,  32'h0,          1'b1, 32'h0,          1'b0);
        apply(4'd0, 32'hffff_ffff,  32'h00ff_00ff,  1'b1, 32'h00ff_00ff,  1'b0);
        apply(4'd1, 32'h0f0f_0f0f,  32'hffff_0000,  1'b1, 32'hffff_0f0f,  1'b0);
        apply(4'd1, 32'h0,          32'h0,          1'b1, 32'h0,          1'b0);
        apply(4'd2, 32'hffff_ffff,  32'h1,          1'b1, 32'h0,          1'b0);
        apply(4'd2, 32'hffff_ffff,  32'd400,        1'b1, 32'd399,        1'b0);
        apply(4'd2, 32'h8000_0000,  32'h8000_0000,  1'b1, 32'h0,          1'b1);
        apply(4'd6, 32'd5,          32'd6,          1'b1, 32'hffff_ffff,  1'b0);
        apply(4'd6, -32'sd15,       -32'sd9,        1'b1, -32'sd6,        1'b0);
        apply(4'd6, 32'h8000_0000,  32'h1,          1'b1, 32'h7fff_ffff,  1'b1);
        apply(4'd6, 32'h0055_5121,  32'h0055_5121,  1'b1, 32'h0,          1'b0);
        apply(4'd6, 32'h7fff_ffff,  32'hffff_ffff,  1'b1, 32'h8000_0000,  1'b1);
        apply(4'd7, 32'hffff_ffff,  32'h1,          1'b1, 32'h1,          1'b0);
        apply(4'd9, 32'hffff_ffff,  32'h1,          1'b1, 32'h0,          1'b0);
        apply(4'd8, 32'h8000_0000,  32'd4,          1'b1, sra_exp,        1'b0);
        apply(4'd4, 32'h1,          32'h25,         1'b1, sll_exp,        1'b0);
        apply(4'd14, 32'd5,         32'd2222,       1'b1, 32'h0,          1'b0);
        apply(4'd15, 32'hffff_ffff, 32'hffff_ffff,  1'b1, 32'h0,          1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic        rst;
            op  = 4'($urandom_range(0, 15));
            a   = pick_operand();
            b   = pick_operand();
            rst = ($urandom_range(0, 19) != 0);
            model(op, a, b, m_r, m_ov);
            apply(op, a, b, rst, m_r, m_ov);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
